// File: rtl/mmu_memory_responder.sv
// rtl/mmu_memory_responder.sv - MMU request endpoint on a 64-bit RAM port with credit-protected in-order read return
//
// Purpose:
//   Accepts MMU requests and issues them straight to a 64-bit backing RAM in the
//   same cycle. Read data comes back from the RAM in command order with variable
//   latency. It is held in a show-ahead return FIFO and handed to the MMU under
//   its backpressure. Reads already issued count against the FIFO depth, so a
//   RAM return always has a free slot and is never dropped.
//
// Ports:
//   iCLOCK, inRESET            clock, async active-low reset
//   iREQ/oLOCK                 request valid / backpressure to the requester
//   iORDER,iMASK,iRW,iADDR,iDATA  request attributes (iMASK selects the byte lanes)
//   oREQ/iLOCK/oDATA           read return valid / requester backpressure / 64-bit beat
//   oRAM_REQ/iRAM_BUSY         RAM command valid / RAM stall
//   oRAM_RW,oRAM_ADDR,oRAM_BYTEEN,oRAM_WDATA  RAM command fields
//   iRAM_VALID/iRAM_RDATA      RAM read return, in command order
//
// Optional feature:
//   MIST1032SA_MEMORY_RESPONDER_BYPASS_EN - when the FIFO is empty, a RAM return
//   is shown on oREQ/oDATA in the same cycle. It skips the FIFO if the requester
//   takes it at once.

module mmu_memory_responder #(
  parameter int P_RDQ_DEPTH   = 8,
  parameter int P_RDQ_DEPTH_N = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ,
  output logic        oLOCK,
  input  logic [1:0]  iORDER,
  input  logic [3:0]  iMASK,
  input  logic        iRW,
  input  logic [31:0] iADDR,
  input  logic [31:0] iDATA,
  output logic        oREQ,
  input  logic        iLOCK,
  output logic [63:0] oDATA,
  output logic        oRAM_REQ,
  input  logic        iRAM_BUSY,
  output logic        oRAM_RW,
  output logic [28:0] oRAM_ADDR,
  output logic [7:0]  oRAM_BYTEEN,
  output logic [63:0] oRAM_WDATA,
  input  logic        iRAM_VALID,
  input  logic [63:0] iRAM_RDATA
);

  localparam logic [P_RDQ_DEPTH_N+1:0] L_DEPTH = (P_RDQ_DEPTH_N+2)'(P_RDQ_DEPTH);
  localparam logic [P_RDQ_DEPTH_N:0]   L_ONE   = (P_RDQ_DEPTH_N+1)'(1);
  localparam logic [P_RDQ_DEPTH_N-1:0] L_PONE  = (P_RDQ_DEPTH_N)'(1);
  localparam logic [P_RDQ_DEPTH_N-1:0] L_LAST  = (P_RDQ_DEPTH_N)'(P_RDQ_DEPTH - 1);

  logic [P_RDQ_DEPTH_N:0]   r_inflight;
  logic [P_RDQ_DEPTH_N:0]   r_rdq_count;
  logic [P_RDQ_DEPTH_N-1:0] r_wr_ptr;
  logic [P_RDQ_DEPTH_N-1:0] r_rd_ptr;
  logic [63:0]              r_mem [P_RDQ_DEPTH];

  logic [P_RDQ_DEPTH_N+1:0] w_credit_sum;
  logic w_credit_full;
  logic w_accept;
  logic w_rd_accept;
  logic w_ret_valid;
  logic w_fifo_nonempty;
  logic w_bypass_take;
  logic w_push;
  logic w_pop;
  logic w_unused_ok;

  // Size and sub-word address bits do not affect the RAM command: iMASK carries the lanes.
  assign w_unused_ok = &{1'b0, iORDER, iADDR[1:0]};

  // Each issued read holds a FIFO slot until it is popped. A full credit stalls
  // every request, including writes, so the lock rule stays simple.
  assign w_credit_sum  = {1'b0, r_inflight} + {1'b0, r_rdq_count};
  assign w_credit_full = w_credit_sum >= L_DEPTH;
  assign oLOCK         = iRAM_BUSY || w_credit_full;

  assign w_accept    = iREQ && !oLOCK;
  assign w_rd_accept = w_accept && !iRW;

  assign oRAM_REQ    = w_accept;
  assign oRAM_RW     = iRW;
  assign oRAM_ADDR   = iADDR[31:3];
  assign oRAM_BYTEEN = iADDR[2] ? {iMASK, 4'b0000} : {4'b0000, iMASK};
  assign oRAM_WDATA  = {iDATA, iDATA};

  // A return with nothing outstanding is a protocol error. Reads that were
  // pending across a reset also land here, and such returns are dropped.
  assign w_ret_valid     = iRAM_VALID && (r_inflight != '0);
  assign w_fifo_nonempty = r_rdq_count != '0;

`ifdef MIST1032SA_MEMORY_RESPONDER_BYPASS_EN
  assign w_bypass_take = w_ret_valid && !w_fifo_nonempty && !iLOCK;
  assign oREQ          = w_fifo_nonempty || w_ret_valid;
  assign oDATA         = w_fifo_nonempty ? r_mem[r_rd_ptr] : (w_ret_valid ? iRAM_RDATA : 64'd0);
`else
  assign w_bypass_take = 1'b0;
  assign oREQ          = w_fifo_nonempty;
  assign oDATA         = w_fifo_nonempty ? r_mem[r_rd_ptr] : 64'd0;
`endif

  assign w_push = w_ret_valid && !w_bypass_take;
  assign w_pop  = w_fifo_nonempty && !iLOCK;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_inflight  <= '0;
      r_rdq_count <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      case ({w_rd_accept, w_ret_valid})
        2'b10:   r_inflight <= r_inflight + L_ONE;
        2'b01:   r_inflight <= r_inflight - L_ONE;
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_rdq_count <= r_rdq_count + L_ONE;
        2'b01:   r_rdq_count <= r_rdq_count - L_ONE;
        default: r_rdq_count <= r_rdq_count;
      endcase
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + L_PONE;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + L_PONE;
      end
    end
  end

  // Storage needs no reset: an entry is only visible after it has been written.
  always_ff @(posedge iCLOCK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= iRAM_RDATA;
    end
  end

endmodule
